// File: rtl/cp0_def_pkg.sv
// rtl/cp0_def_pkg.sv - shared cp0 widths and exception codes
package cp0_def_pkg;

    localparam int EXC_CODE_WIDTH = 5;
    localparam int INT_MASK_WIDTH = 8;

    localparam logic [EXC_CODE_WIDTH-1:0] EC_INT     = 5'd0;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_TLB_MOD = 5'd1;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_TLBL    = 5'd2;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_TLBS    = 5'd3;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_ADEL    = 5'd4;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_ADES    = 5'd5;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_SYSCALL = 5'd8;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_RI      = 5'd10;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_NONE    = 5'd30;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_ERET    = 5'd31;

endpackage

// File: rtl/int_sync.sv
// rtl/int_sync.sv - multi-stage synchroniser for asynchronous interrupt lines
module int_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/exc_arbiter.sv
// rtl/exc_arbiter.sv - MEM-stage exception/interrupt arbiter feeding cp0
module exc_arbiter
    import cp0_def_pkg::*;
#(
    parameter int HW_INT_W    = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               status,
    input  logic [1:0]                sw_int,
    input  logic [HW_INT_W-1:0]       hw_int,
    input  logic                      int_timer_req,
    input  logic                      mem_insn_valid,
    input  logic [31:0]               mem_pc,
    input  logic                      mem_in_delay_slot,
    input  logic [EXC_CODE_WIDTH-1:0] mem_exc_code,
    input  logic [31:0]               mem_badvaddr,
    input  logic                      mem_eret,
    input  logic                      exc_jmp_flag,
    output logic [EXC_CODE_WIDTH-1:0] exc_code,
    output logic [31:0]               exc_epc,
    output logic [31:0]               exc_badvaddr,
    output logic [INT_MASK_WIDTH-1:0] cause_ip,
    output logic                      pipe_stall,
    output logic                      pipe_flush
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                    state, state_next;
    logic [HW_INT_W-1:0]       hw_sync;
    logic                      int_pend;
    logic                      detect;
    logic [EXC_CODE_WIDTH-1:0] sel_code;
    logic [31:0]               sel_epc;
    logic [31:0]               sel_badvaddr;
    logic [31:0]               commit_epc;
    logic                      unused_status;

    int_sync #(
        .WIDTH  (HW_INT_W),
        .STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk (clk),
        .rst (rst),
        .d   (hw_int),
        .q   (hw_sync)
    );

    // Timer shares the top hardware line, so it bypasses the synchroniser.
    always_ff @(posedge clk) begin
        if (rst) begin
            cause_ip <= '0;
        end else begin
            cause_ip <= {hw_sync[HW_INT_W-1] | int_timer_req, hw_sync[HW_INT_W-2:0], sw_int};
        end
    end

    assign int_pend      = status[0] & ~status[1] & (|(cause_ip & status[15:8]));
    assign commit_epc    = mem_in_delay_slot ? (mem_pc - 32'd4) : mem_pc;
    assign unused_status = ^{status[31:16], status[7:2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        detect       = 1'b0;
        sel_code     = EC_NONE;
        sel_epc      = '0;
        sel_badvaddr = '0;
        pipe_flush   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_insn_valid) begin
                    if (int_pend) begin
                        detect   = 1'b1;
                        sel_code = EC_INT;
                        sel_epc  = commit_epc;
                    end else if (mem_exc_code != EC_NONE) begin
                        detect       = 1'b1;
                        sel_code     = mem_exc_code;
                        sel_epc      = commit_epc;
                        sel_badvaddr = mem_badvaddr;
                    end else if (mem_eret) begin
                        detect   = 1'b1;
                        sel_code = EC_ERET;
                    end
                end
                if (detect) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (exc_jmp_flag) begin
                    pipe_flush = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign pipe_stall = (state != ST_IDLE) | detect;

    // exc_code is live only during ISSUE; epc/badvaddr hold until the next event.
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_code     <= EC_NONE;
            exc_epc      <= '0;
            exc_badvaddr <= '0;
        end else if (detect) begin
            exc_code     <= sel_code;
            exc_epc      <= sel_epc;
            exc_badvaddr <= sel_badvaddr;
        end else begin
            exc_code     <= EC_NONE;
        end
    end

endmodule

// File: tb/tb_exc_arbiter.sv
// tb/tb_exc_arbiter.sv - directed scoreboard bench for exc_arbiter
module tb_exc_arbiter;
    import cp0_def_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [31:0]               status;
    logic [1:0]                sw_int;
    logic [5:0]                hw_int;
    logic                      int_timer_req;
    logic                      mem_insn_valid;
    logic [31:0]               mem_pc;
    logic                      mem_in_delay_slot;
    logic [EXC_CODE_WIDTH-1:0] mem_exc_code;
    logic [31:0]               mem_badvaddr;
    logic                      mem_eret;
    logic                      exc_jmp_flag;
    logic [EXC_CODE_WIDTH-1:0] exc_code;
    logic [31:0]               exc_epc;
    logic [31:0]               exc_badvaddr;
    logic [INT_MASK_WIDTH-1:0] cause_ip;
    logic                      pipe_stall;
    logic                      pipe_flush;

    typedef struct {
        logic [EXC_CODE_WIDTH-1:0] code;
        logic [31:0]               epc;
        logic [31:0]               bad;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    exc_arbiter #(.HW_INT_W(6), .SYNC_STAGES(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .status            (status),
        .sw_int            (sw_int),
        .hw_int            (hw_int),
        .int_timer_req     (int_timer_req),
        .mem_insn_valid    (mem_insn_valid),
        .mem_pc            (mem_pc),
        .mem_in_delay_slot (mem_in_delay_slot),
        .mem_exc_code      (mem_exc_code),
        .mem_badvaddr      (mem_badvaddr),
        .mem_eret          (mem_eret),
        .exc_jmp_flag      (exc_jmp_flag),
        .exc_code          (exc_code),
        .exc_epc           (exc_epc),
        .exc_badvaddr      (exc_badvaddr),
        .cause_ip          (cause_ip),
        .pipe_stall        (pipe_stall),
        .pipe_flush        (pipe_flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [4:0] code, input logic [31:0] epc, input logic [31:0] badv);
        exp_t e;
        e.code = code;
        e.epc  = epc;
        e.bad  = badv;
        sb.push_back(e);
    endtask

    // Inputs for cycle N are already driven; walks N, N+1, N+2 and optionally N+3.
    task automatic run_event(input string tag, input bit do_jmp);
        exp_t e;
        @(negedge clk);
        check({tag, "_stall_n"}, 32'(pipe_stall), 32'd1);
        check({tag, "_code_n"}, 32'(exc_code), 32'(EC_NONE));
        tick();
        mem_insn_valid = 1'b0;
        mem_exc_code   = EC_NONE;
        mem_eret       = 1'b0;
        @(negedge clk);
        total++;
        assert (sb.size() > 0 && exc_code !== EC_NONE) else begin
            bad++;
            $error("FAIL %s_req observed=%h expected=request sb_size=%0d", tag, exc_code, sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_code"}, 32'(exc_code), 32'(e.code));
            check({tag, "_epc"}, exc_epc, e.epc);
            check({tag, "_badvaddr"}, exc_badvaddr, e.bad);
        end
        check({tag, "_stall_n1"}, 32'(pipe_stall), 32'd1);
        tick();
        exc_jmp_flag = do_jmp;
        @(negedge clk);
        check({tag, "_code_n2"}, 32'(exc_code), 32'(EC_NONE));
        check({tag, "_flush_n2"}, 32'(pipe_flush), 32'(do_jmp));
        check({tag, "_stall_n2"}, 32'(pipe_stall), 32'd1);
        if (do_jmp) begin
            tick();
            exc_jmp_flag = 1'b0;
            @(negedge clk);
            check({tag, "_stall_n3"}, 32'(pipe_stall), 32'd0);
            check({tag, "_flush_n3"}, 32'(pipe_flush), 32'd0);
        end
    endtask

    initial begin
        rst               = 1'b1;
        status            = '0;
        sw_int            = '0;
        hw_int            = 6'h3f;
        int_timer_req     = 1'b0;
        mem_insn_valid    = 1'b0;
        mem_pc            = '0;
        mem_in_delay_slot = 1'b0;
        mem_exc_code      = EC_NONE;
        mem_badvaddr      = '0;
        mem_eret          = 1'b0;
        exc_jmp_flag      = 1'b0;

        repeat (3) tick();
        @(negedge clk);
        check("rst_code", 32'(exc_code), 32'(EC_NONE));
        check("rst_epc", exc_epc, 32'h0);
        check("rst_badvaddr", exc_badvaddr, 32'h0);
        check("rst_cause_ip", 32'(cause_ip), 32'h0);
        check("rst_stall", 32'(pipe_stall), 32'd0);
        check("rst_flush", 32'(pipe_flush), 32'd0);
        rst    = 1'b0;
        hw_int = '0;
        tick();

        // Syscall, not in a delay slot, interrupts disabled.
        mem_insn_valid = 1'b1;
        mem_exc_code   = EC_SYSCALL;
        mem_pc         = 32'h8000_1000;
        mem_badvaddr   = 32'hdead_beef;
        push_exp(EC_SYSCALL, 32'h8000_1000, 32'hdead_beef);
        run_event("sys", 1'b1);

        // TLBL in a delay slot: EPC points at the branch.
        tick();
        mem_insn_valid    = 1'b1;
        mem_exc_code      = EC_TLBL;
        mem_pc            = 32'h0040_0008;
        mem_in_delay_slot = 1'b1;
        mem_badvaddr      = 32'h1234_5678;
        push_exp(EC_TLBL, 32'h0040_0004, 32'h1234_5678);
        run_event("tlbl", 1'b1);
        mem_in_delay_slot = 1'b0;

        // Delay slot at address 0 wraps the EPC.
        tick();
        mem_insn_valid    = 1'b1;
        mem_exc_code      = EC_ADES;
        mem_pc            = 32'h0000_0000;
        mem_in_delay_slot = 1'b1;
        mem_badvaddr      = 32'h0000_0003;
        push_exp(EC_ADES, 32'hffff_fffc, 32'h0000_0003);
        run_event("wrap", 1'b1);
        mem_in_delay_slot = 1'b0;

        // Interrupt line through the synchroniser.
        tick();
        status = 32'h0000_8001;
        hw_int = 6'h20;
        tick();
        tick();
        @(negedge clk);
        check("ip_lat2", 32'(cause_ip), 32'h00);
        tick();
        @(negedge clk);
        check("ip_lat3", 32'(cause_ip), 32'h80);

        // Pending interrupt wins over a simultaneous RI.
        tick();
        mem_insn_valid = 1'b1;
        mem_exc_code   = EC_RI;
        mem_pc         = 32'h8000_2000;
        mem_badvaddr   = 32'h5555_aaaa;
        push_exp(EC_INT, 32'h8000_2000, 32'h0);
        run_event("int", 1'b1);

        // EXL set: interrupt masked.
        tick();
        status         = 32'h0000_8003;
        mem_insn_valid = 1'b1;
        mem_pc         = 32'h8000_3000;
        @(negedge clk);
        check("exl_stall", 32'(pipe_stall), 32'd0);
        tick();
        @(negedge clk);
        check("exl_code", 32'(exc_code), 32'(EC_NONE));

        // IM[7] clear: interrupt masked.
        status = 32'h0000_7f01;
        @(negedge clk);
        check("im_stall", 32'(pipe_stall), 32'd0);
        tick();
        @(negedge clk);
        check("im_code", 32'(exc_code), 32'(EC_NONE));
        mem_insn_valid = 1'b0;
        hw_int         = '0;
        status         = '0;

        // Timer and software bits land one cycle after they are driven.
        tick();
        int_timer_req = 1'b1;
        sw_int        = 2'b01;
        tick();
        @(negedge clk);
        check("timer_ip", 32'(cause_ip), 32'h81);
        int_timer_req = 1'b0;
        sw_int        = 2'b00;
        tick();
        @(negedge clk);
        check("timer_ip_clr", 32'(cause_ip), 32'h00);

        // Stray jump pulse in IDLE.
        exc_jmp_flag = 1'b1;
        @(negedge clk);
        check("idle_jmp_flush", 32'(pipe_flush), 32'd0);
        tick();
        exc_jmp_flag = 1'b0;

        // ERET, then reset while waiting for cp0.
        mem_insn_valid = 1'b1;
        mem_eret       = 1'b1;
        mem_pc         = 32'h8000_4000;
        push_exp(EC_ERET, 32'h0, 32'h0);
        run_event("eret", 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstw_stall", 32'(pipe_stall), 32'd0);
        check("rstw_code", 32'(exc_code), 32'(EC_NONE));
        exc_jmp_flag = 1'b1;
        @(negedge clk);
        check("rstw_late_flush", 32'(pipe_flush), 32'd0);
        tick();
        exc_jmp_flag = 1'b0;
        @(negedge clk);
        check("rstw_stall_after", 32'(pipe_stall), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
